// File: rtl/pe_bfly_gen.sv
// rtl/pe_bfly_gen.sv - handshaked modular butterfly PE (CT / GS / MUL / BYPASS); optional GS halving under macro PE_GS_HALF_EN
module pe_bfly_gen #(
   parameter int DATA_W  = 12,
   parameter int Q       = 3329,
   parameter int MUL_LAT = 3,
   parameter int TAG_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_w,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);
   localparam int LAT = MUL_LAT + 2;
   localparam int PW  = 2 * DATA_W;
   localparam logic [DATA_W:0] QX = (DATA_W+1)'(Q);

   localparam logic [1:0] MODE_CT  = 2'b00;
   localparam logic [1:0] MODE_GS  = 2'b01;
   localparam logic [1:0] MODE_MUL = 2'b10;

   // Operands are already reduced, so one conditional correction suffices.
   function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
      logic [DATA_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= QX) s = s - QX;
      return s[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
      logic [DATA_W:0] d;
      d = {1'b0, x} - {1'b0, y};
      if (x < y) d = d + QX;
      return d[DATA_W-1:0];
   endfunction

   // Exact residue of a full-width product; constant divisor.
   function automatic logic [DATA_W-1:0] red_mod(input logic [PW-1:0] v);
      logic [PW-1:0] r;
      r = v % PW'(Q);
      return DATA_W'(r);
   endfunction

`ifdef PE_GS_HALF_EN
   // v * 2^-1 mod Q: odd values borrow Q (Q odd) to become even before the shift.
   function automatic logic [DATA_W-1:0] half_mod(input logic [DATA_W-1:0] v);
      logic [DATA_W:0] t;
      t = v[0] ? ({1'b0, v} + QX) : {1'b0, v};
      return DATA_W'(t >> 1);
   endfunction
`endif

   logic              adv;
   logic [LAT:1]      vld;
   logic [1:0]        mode_q [1:LAT-1];
   logic [TAG_W-1:0]  tag_q  [1:LAT-1];
   logic [DATA_W-1:0] u_q    [1:LAT-1];   // operand that bypasses the multiplier
   logic [DATA_W-1:0] m_q    [1:LAT-1];   // multiplier operand, also the bypass y value
   logic [DATA_W-1:0] w_q;
   logic [PW-1:0]     mul_full;
   logic [DATA_W-1:0] p_res_q;            // multiplier result, aligned with stage LAT-1
   logic [DATA_W-1:0] u_nx, m_nx;
   logic [DATA_W-1:0] x_nx, y_nx;

   assign adv       = !vld[LAT] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[LAT];
   assign busy      = |vld;
   assign mul_full  = PW'(m_q[1]) * PW'(w_q);

   // Stage 1 pre-add/sub: choose what feeds the multiplier and what goes around it.
   always_comb begin
      u_nx = in_a;
      m_nx = in_b;
      case (in_mode)
         MODE_GS: begin
            u_nx = add_mod(in_a, in_b);
            m_nx = sub_mod(in_a, in_b);
         end
         MODE_MUL: begin
            u_nx = in_b;
            m_nx = in_a;
         end
         default: ;
      endcase
   end

   // Stage LAT post-add/sub (and halving for GS when enabled).
   always_comb begin
      x_nx = u_q[LAT-1];
      y_nx = m_q[LAT-1];
      case (mode_q[LAT-1])
         MODE_CT: begin
            x_nx = add_mod(u_q[LAT-1], p_res_q);
            y_nx = sub_mod(u_q[LAT-1], p_res_q);
         end
         MODE_GS: begin
`ifdef PE_GS_HALF_EN
            x_nx = half_mod(u_q[LAT-1]);
            y_nx = half_mod(p_res_q);
`else
            x_nx = u_q[LAT-1];
            y_nx = p_res_q;
`endif
         end
         MODE_MUL: begin
            x_nx = p_res_q;
            y_nx = u_q[LAT-1];
         end
         default: ;
      endcase
   end

   // Valid bits and output register: reset clears them, otherwise they move only on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld     <= '0;
         out_x   <= '0;
         out_y   <= '0;
         out_tag <= '0;
      end else if (adv) begin
         vld     <= {vld[LAT-1:1], in_valid};
         out_x   <= x_nx;
         out_y   <= y_nx;
         out_tag <= tag_q[LAT-1];
      end
   end

   // Payload shift register for stages 1..LAT-1; contents are qualified by vld.
   always_ff @(posedge clk) begin
      if (adv) begin
         mode_q[1] <= in_mode;
         tag_q[1]  <= in_tag;
         u_q[1]    <= u_nx;
         m_q[1]    <= m_nx;
         w_q       <= in_w;
         for (int i = 2; i < LAT; i++) begin
            mode_q[i] <= mode_q[i-1];
            tag_q[i]  <= tag_q[i-1];
            u_q[i]    <= u_q[i-1];
            m_q[i]    <= m_q[i-1];
         end
      end
   end

   generate
      if (MUL_LAT == 1) begin : g_mul_one
         // Single multiplier stage: multiply and reduce together.
         always_ff @(posedge clk) begin
            if (adv) p_res_q <= red_mod(mul_full);
         end
      end else begin : g_mul_multi
         logic [PW-1:0] prod_q [0:MUL_LAT-2];
         // Product first, delay through spare stages, reduce in the last multiplier stage.
         always_ff @(posedge clk) begin
            if (adv) begin
               prod_q[0] <= mul_full;
               for (int i = 1; i < MUL_LAT-1; i++) prod_q[i] <= prod_q[i-1];
               p_res_q <= red_mod(prod_q[MUL_LAT-2]);
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_pe_bfly_gen.sv
// tb/tb_pe_bfly_gen.sv - self-checking bench for pe_bfly_gen against a modular-arithmetic reference model
module tb_pe_bfly_gen;
   localparam int DW  = 12;
   localparam int Q   = 3329;
   localparam int ML  = 3;
   localparam int TW  = 8;
   localparam int LAT = ML + 2;
   localparam longint INV2 = (Q + 1) / 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_mode = 2'b00;
   logic [DW-1:0] in_a = '0, in_b = '0, in_w = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_x, out_y;
   logic [TW-1:0] out_tag;
   logic          busy;

   pe_bfly_gen #(.DATA_W(DW), .Q(Q), .MUL_LAT(ML), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int x;
      int y;
      int tag;
      int rem;
      int t;
      bit lat_chk;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   delivered = 0;
   int   fix_x = -1;
   int   fix_y = -1;
   bit   lat_next = 1'b0;
   bit   last_acc = 1'b0;

   task automatic chk(input string nm, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
      end
   endtask

   function automatic void model(input int md, input int a, input int b, input int w, output int x, output int y);
      longint la, lb, lw, s, d, p;
      la = longint'(a); lb = longint'(b); lw = longint'(w);
      case (md)
         0: begin
            p = (lb * lw) % Q;
            x = int'((la + p) % Q);
            y = int'((la - p + Q) % Q);
         end
         1: begin
            s = (la + lb) % Q;
            d = (((la - lb + Q) % Q) * lw) % Q;
`ifdef PE_GS_HALF_EN
            s = (s * INV2) % Q;
            d = (d * INV2) % Q;
`endif
            x = int'(s);
            y = int'(d);
         end
         2: begin
            x = int'((la * lw) % Q);
            y = b;
         end
         default: begin
            x = a;
            y = b;
         end
      endcase
   endfunction

   task automatic step(input bit v, input logic [1:0] md, input int a, input int b, input int w, input int tg, input bit ordy);
      bit   ov_e, adv_e;
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_mode   = md;
      in_a      = DW'(a);
      in_b      = DW'(b);
      in_w      = DW'(w);
      in_tag    = TW'(tg);
      out_ready = ordy;
      #1;
      ov_e  = (q.size() > 0) && (q[0].rem == 0);
      adv_e = !ov_e || ordy;
      chk("out_valid", longint'(out_valid), longint'(ov_e));
      chk("busy", longint'(busy), longint'(q.size() > 0));
      chk("in_ready", longint'(in_ready), longint'(adv_e));
      if (ov_e) begin
         chk("out_x", longint'(out_x), longint'(q[0].x));
         chk("out_y", longint'(out_y), longint'(q[0].y));
         chk("out_tag", longint'(out_tag), longint'(q[0].tag));
         if (ordy) begin
            if (q[0].lat_chk) chk("latency", longint'(cyc - q[0].t), longint'(LAT));
            void'(q.pop_front());
         end
      end
      if (out_valid && out_ready) delivered++;
      if (adv_e) begin
         for (int i = 0; i < q.size(); i++)
            if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
      end
      last_acc = v && adv_e;
      if (last_acc) begin
         model(int'(md), a, b, w, e.x, e.y);
         if (fix_x >= 0) e.x = fix_x;
         if (fix_y >= 0) e.y = fix_y;
         e.tag     = tg % (1 << TW);
         e.rem     = LAT - 1;
         e.t       = cyc;
         e.lat_chk = lat_next;
         q.push_back(e);
         fix_x    = -1;
         fix_y    = -1;
         lat_next = 1'b0;
      end
   endtask

   task automatic drain(input bit rnd);
      for (int k = 0; k < 100 && q.size() > 0; k++)
         step(1'b0, 2'b00, 0, 0, 0, 0, rnd ? 1'($urandom_range(1)) : 1'b1);
      step(1'b0, 2'b00, 0, 0, 0, 0, 1'b1);
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (ncyc - 1) @(negedge clk);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_x", longint'(out_x), 0);
      chk("rst_out_y", longint'(out_y), 0);
      chk("rst_out_tag", longint'(out_tag), 0);
   endtask

   initial begin
      int idx;
      int d0;

      do_reset(3);

      fix_x = 35; fix_y = 3296; lat_next = 1'b1;
      step(1'b1, 2'b00, 1, 2, 17, 8'hA5, 1'b1);
      drain(1'b0);

`ifdef PE_GS_HALF_EN
      fix_x = 1668; fix_y = 1690;
`else
      fix_x = 7; fix_y = 51;
`endif
      lat_next = 1'b1;
      step(1'b1, 2'b01, 5, 2, 17, 8'h3C, 1'b1);
      drain(1'b0);

      fix_x = 3327; fix_y = 0;
      step(1'b1, 2'b00, 3328, 3328, 1, 8'h11, 1'b1);
      fix_x = 1; fix_y = 1234;
      step(1'b1, 2'b10, 3328, 1234, 3328, 8'h22, 1'b1);
      step(1'b1, 2'b11, 77, 3000, 5, 8'h33, 1'b1);
      drain(1'b0);

      for (int i = 0; i < 20; i++)
         step(1'b1, 2'(i % 4), int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)),
              int'($urandom_range(Q - 1)), i, 1'b1);
      drain(1'b0);

      d0  = delivered;
      idx = 0;
      for (int k = 0; k < 200 && idx < 10; k++) begin
         step(1'b1, 2'($urandom_range(3)), int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)),
              int'($urandom_range(Q - 1)), 100 + idx, 1'($urandom_range(1)));
         if (last_acc) idx++;
      end
      drain(1'b1);
      chk("bp_delivered", longint'(delivered - d0), 10);

      for (int i = 0; i < 3; i++)
         step(1'b1, 2'(i), int'($urandom_range(Q - 1)), int'($urandom_range(Q - 1)),
              int'($urandom_range(Q - 1)), 200 + i, 1'b1);
      do_reset(1);
      lat_next = 1'b1;
      step(1'b1, 2'b00, 1, 2, 17, 8'h5A, 1'b1);
      drain(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
